tone_sequencer: RTL

Parametrised multi-channel square-wave tone generator driven by the 50 MHz system clock. Each channel accepts a note command (half-period in clocks, duration in time-base ticks), plays it, inserts a fixed inter-note gap, then signals completion. It sits between the processor's note-issuing logic and the speaker pins; a shared prescaler supplies the millisecond time base.

---
 rtl/tone_pkg.sv | 11 +
 rtl/tone_channel.sv | 89 ++++++++
 rtl/tone_sequencer.sv | 69 ++++++
 3 files changed

// File: rtl/tone_pkg.sv
// tone_pkg: shared channel FSM states, 50 MHz time-base default and note-command layout
package tone_pkg;
    localparam int DEF_TICK_DIV = 50_000;
    localparam int DEF_PERIOD_W = 20;
    localparam int DEF_DUR_W    = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_e;
    typedef struct packed {
        logic [DEF_PERIOD_W-1:0] half_period;
        logic [DEF_DUR_W-1:0]    duration;
    } note_cmd_t;
endpackage

// File: rtl/tone_channel.sv
// tone_channel: one note player: square-wave generator, tick-driven duration and trailing gap
module tone_channel
    import tone_pkg::*;
#(
    parameter int PERIOD_W  = DEF_PERIOD_W,
    parameter int DUR_W     = DEF_DUR_W,
    parameter int GAP_TICKS = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                wr_en,
    input  logic [PERIOD_W-1:0] wr_half_period,
    input  logic [DUR_W-1:0]    wr_duration,
    output logic                busy,
    output logic                done,
    output logic                tone_out
);
    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] hp_q, hp_d, tcnt_q, tcnt_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                tone_q, tone_d, done_q, done_d, last;
    assign last     = tcnt_q == hp_q - 1'b1;
    assign busy     = state_q != IDLE;
    assign done     = done_q;
    assign tone_out = tone_q;
    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        tcnt_d  = tcnt_q;
        dur_d   = dur_q;
        gap_d   = gap_q;
        tone_d  = tone_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (wr_en) begin
                hp_d    = wr_half_period;
                dur_d   = wr_duration;
                tcnt_d  = '0;
                tone_d  = 1'b0;
                done_d  = wr_duration == '0;
                state_d = (wr_duration == '0) ? IDLE : PLAY;
            end
            PLAY: begin
                if (hp_q != '0) begin
                    tcnt_d = last ? '0 : tcnt_q + 1'b1;
                    tone_d = tone_q ^ last;
                end
                if (tick && dur_q == DUR_W'(1)) begin
                    // note over: silence immediately, then either gap or finish
                    tone_d  = 1'b0;
                    tcnt_d  = '0;
                    gap_d   = GAP_W'(GAP_TICKS);
                    done_d  = GAP_TICKS == 0;
                    state_d = (GAP_TICKS == 0) ? IDLE : GAP;
                end else if (tick) begin
                    dur_d = dur_q - 1'b1;
                end
            end
            GAP: if (tick) begin
                gap_d   = gap_q - 1'b1;
                done_d  = gap_q == GAP_W'(1);
                state_d = (gap_q == GAP_W'(1)) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hp_q    <= '0;
            tcnt_q  <= '0;
            dur_q   <= '0;
            gap_q   <= '0;
            tone_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            tcnt_q  <= tcnt_d;
            dur_q   <= dur_d;
            gap_q   <= gap_d;
            tone_q  <= tone_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: multi-channel square-wave tone player with shared tick prescaler
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int PERIOD_W  = DEF_PERIOD_W,
    parameter int DUR_W     = DEF_DUR_W,
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int GAP_TICKS = 10,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [PERIOD_W-1:0] wr_half_period,
    input  logic [DUR_W-1:0]    wr_duration,
    output logic                wr_ready,
    output logic [NUM_CH-1:0]   busy,
    output logic [NUM_CH-1:0]   done,
    output logic [NUM_CH-1:0]   tone_out,
    output logic                speaker,
    output logic                led
);
    localparam int PS_W = $clog2(TICK_DIV);
    localparam int PAD  = 2 ** CH_W;
    logic [PS_W-1:0] cnt_q, cnt_d;
    logic            tick, speaker_q, speaker_d, led_q, led_d;
    logic [PAD-1:0]  busy_pad;
    assign tick     = cnt_q == PS_W'(TICK_DIV - 1);
    // unpopulated channel numbers read as never ready
    assign busy_pad = PAD'(busy);
    assign wr_ready = (int'(wr_ch) < NUM_CH) && !busy_pad[wr_ch];
    assign speaker  = speaker_q;
    assign led      = led_q;
    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        speaker_d = |tone_out;
        led_d     = |busy;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            speaker_q <= 1'b0;
            led_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            speaker_q <= speaker_d;
            led_q     <= led_d;
        end
    end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tone_channel #(
            .PERIOD_W (PERIOD_W),
            .DUR_W    (DUR_W),
            .GAP_TICKS(GAP_TICKS)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .tick          (tick),
            .wr_en         (wr_en && wr_ch == CH_W'(i)),
            .wr_half_period(wr_half_period),
            .wr_duration   (wr_duration),
            .busy          (busy[i]),
            .done          (done[i]),
            .tone_out      (tone_out[i])
        );
    end
endmodule
